// File: rtl/patch_bus_master.sv
// Purpose : initiator on the synth parameter register bus; dumps all claimed registers as a byte
//           stream, or loads a byte stream back into them, in one fixed sweep order.
// Latency : per register 1 setup + STROBE_CYC strobe + 1 emit/release cycle, plus 1 cycle per
//           address step in NEXT. Backpressure: a dump byte holds in RD_EMIT until dout_ready;
//           a load waits in WR_WAIT (din_ready=1) for din_valid.
// Ports   : sCLK_XVXENVS/reset_reg_N clock and async active-low reset; dump_start/load_start/abort
//           control; busy/done status; dout* dump stream; din* load stream; data/adr/write/read,
//           bank selects and sysex_data_patch_send drive the register bus; chk_err load checksum flag.
// Option  : define PATCH_CHECKSUM_EN to append/consume a 7-bit checksum byte (CHK state).
module patch_bus_master #(
  parameter int V_OSC      = 4,
  parameter int STROBE_CYC = 2
) (
  input  logic       sCLK_XVXENVS,
  input  logic       reset_reg_N,
  input  logic       dump_start,
  input  logic       load_start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  inout  wire  [7:0] data,
  output logic [6:0] adr,
  output logic       write,
  output logic       read,
  output logic       sysex_data_patch_send,
  output logic       com_sel,
  output logic       osc_sel,
  output logic       m1_sel,
  output logic       m2_sel,
  output logic       chk_err
);

  typedef enum logic [3:0] {
    IDLE, RD_SETUP, RD_STROBE, RD_EMIT, WR_WAIT, WR_SETUP, WR_STROBE, WR_REL, NEXT,
`ifdef PATCH_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_e;

  localparam int         CW        = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [6:0] BANK_LAST = 7'(V_OSC * 16 - 1);

  state_e          state_q;
  logic            dump_q;           // 1 = dump sweep, 0 = load sweep
  logic [1:0]      bank_q;           // 0 com, 1 osc, 2 m1, 3 m2
  logic [6:0]      pos_q;            // sweep position within bank_q
  logic [6:0]      adr_q;
  logic [3:0]      sel_q;
  logic            send_q, read_q, write_q, data_oe_q;
  logic [7:0]      data_q, dout_q;
  logic            dout_vld_q, din_rdy_q, busy_q, done_q;
  logic [CW-1:0]   cnt_q;

  // Next sweep position, computed from the current one.
  logic            last_in_bank, sweep_end;
  logic [6:0]      nxt_adr_d;
  logic [1:0]      nxt_bank_d;

  // Registers the osc responder decodes inside each 16-address oscillator slot.
  function automatic logic claimed(input logic [1:0] b, input logic [6:0] a);
    case (b)
      2'd0:    claimed = (a >= 7'd1) && (a <= 7'd15);
      2'd1:    claimed = (a <= BANK_LAST) &&
                         ((a[3:0] inside {4'd2, 4'd3, 4'd4, 4'd7}) || (a[3:0] >= 4'd10));
      default: claimed = (a <= BANK_LAST);
    endcase
  endfunction

  always_comb begin
    last_in_bank = (bank_q == 2'd0) ? (pos_q == 7'd15) : (pos_q == BANK_LAST);
    nxt_adr_d    = last_in_bank ? 7'd0 : pos_q + 7'd1;
    nxt_bank_d   = last_in_bank ? bank_q + 2'd1 : bank_q;
    sweep_end    = last_in_bank && (bank_q == 2'd3);
  end

`ifdef PATCH_CHECKSUM_EN
  logic [6:0] sum_q;
  logic       chk_err_q;
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q    <= IDLE;
      dump_q     <= 1'b0;
      bank_q     <= 2'd0;
      pos_q      <= 7'd0;
      adr_q      <= 7'd0;
      sel_q      <= 4'd0;
      send_q     <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b1;
      data_q     <= 8'd0;
      data_oe_q  <= 1'b0;
      dout_q     <= 8'd0;
      dout_vld_q <= 1'b0;
      din_rdy_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
`ifdef PATCH_CHECKSUM_EN
      sum_q      <= 7'd0;
      chk_err_q  <= 1'b0;
`endif
    end else if (abort && state_q != IDLE) begin
      // Releasing write here gives responders only a rising edge; whatever they latched stays.
      state_q    <= IDLE;
      read_q     <= 1'b0;
      write_q    <= 1'b1;
      data_oe_q  <= 1'b0;
      sel_q      <= 4'd0;
      send_q     <= 1'b0;
      dout_vld_q <= 1'b0;
      din_rdy_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dump_start || load_start) begin
            busy_q <= 1'b1;
            dump_q <= dump_start;
            bank_q <= 2'd0;
            pos_q  <= 7'd1;
`ifdef PATCH_CHECKSUM_EN
            sum_q     <= 7'd0;
            chk_err_q <= 1'b0;
`endif
            if (dump_start) begin
              state_q <= RD_SETUP;
              adr_q   <= 7'd1;
              sel_q   <= 4'b0001;
              send_q  <= 1'b1;
            end else begin
              state_q   <= WR_WAIT;
              din_rdy_q <= 1'b1;
            end
          end
        end
        RD_SETUP: begin
          state_q <= RD_STROBE;
          read_q  <= 1'b1;
          cnt_q   <= '0;
        end
        RD_STROBE: begin
          if (cnt_q == CW'(STROBE_CYC - 1)) begin
            read_q     <= 1'b0;
            dout_q     <= data;
            dout_vld_q <= 1'b1;
            state_q    <= RD_EMIT;
`ifdef PATCH_CHECKSUM_EN
            sum_q      <= sum_q + data[6:0];
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RD_EMIT: begin
          if (dout_ready) begin
            dout_vld_q <= 1'b0;
            state_q    <= NEXT;
          end
        end
        WR_WAIT: begin
          if (din_valid && din_rdy_q) begin
            din_rdy_q <= 1'b0;
            data_q    <= din;
            data_oe_q <= 1'b1;
            adr_q     <= pos_q;
            sel_q     <= 4'(4'b0001 << bank_q);
            state_q   <= WR_SETUP;
`ifdef PATCH_CHECKSUM_EN
            sum_q     <= sum_q + din[6:0];
`endif
          end
        end
        WR_SETUP: begin
          write_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= WR_STROBE;
        end
        WR_STROBE: begin
          if (cnt_q == CW'(STROBE_CYC - 1)) begin
            write_q <= 1'b1;
            state_q <= WR_REL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WR_REL: begin
          data_oe_q <= 1'b0;
          state_q   <= NEXT;
        end
        NEXT: begin
          if (sweep_end) begin
`ifdef PATCH_CHECKSUM_EN
            state_q <= CHK;
            if (dump_q) begin
              dout_q     <= {1'b0, 7'(7'd0 - sum_q)};
              dout_vld_q <= 1'b1;
            end else begin
              din_rdy_q  <= 1'b1;
            end
`else
            state_q <= DONE;
            done_q  <= 1'b1;
            sel_q   <= 4'd0;
            send_q  <= 1'b0;
`endif
          end else begin
            pos_q  <= nxt_adr_d;
            bank_q <= nxt_bank_d;
            // Unclaimed addresses are stepped over here, one per cycle, without any strobe.
            if (claimed(nxt_bank_d, nxt_adr_d)) begin
              if (dump_q) begin
                state_q <= RD_SETUP;
                adr_q   <= nxt_adr_d;
                sel_q   <= 4'(4'b0001 << nxt_bank_d);
              end else begin
                state_q   <= WR_WAIT;
                din_rdy_q <= 1'b1;
              end
            end
          end
        end
`ifdef PATCH_CHECKSUM_EN
        CHK: begin
          if (dump_q ? (dout_vld_q && dout_ready) : (din_valid && din_rdy_q)) begin
            if (!dump_q) chk_err_q <= (7'(sum_q + din[6:0]) != 7'd0);
            dout_vld_q <= 1'b0;
            din_rdy_q  <= 1'b0;
            state_q    <= DONE;
            done_q     <= 1'b1;
            sel_q      <= 4'd0;
            send_q     <= 1'b0;
          end
        end
`endif
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data                  = data_oe_q ? data_q : 8'hzz;
  assign adr                   = adr_q;
  assign write                 = write_q;
  assign read                  = read_q;
  assign sysex_data_patch_send = send_q;
  assign {m2_sel, m1_sel, osc_sel, com_sel} = sel_q;
  assign dout                  = dout_q;
  assign dout_valid            = dout_vld_q;
  assign din_ready             = din_rdy_q;
  assign busy                  = busy_q;
  assign done                  = done_q;

endmodule

// File: tb/tb_patch_bus_master.sv
`timescale 1ns/1ps
module tb_patch_bus_master;
  localparam int V_OSC = 4;
  localparam int NREG  = 183;
`ifdef PATCH_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       dump_start = 1'b0, load_start = 1'b0, abort = 1'b0;
  logic       dout_ready = 1'b0, din_valid = 1'b0;
  logic [7:0] din = 8'd0;
  logic       busy, done, dout_valid, din_ready, write, read, send;
  logic       com_sel, osc_sel, m1_sel, m2_sel, chk_err;
  logic [7:0] dout;
  logic [6:0] adr;
  wire  [7:0] data_bus;

  patch_bus_master #(.V_OSC(V_OSC), .STROBE_CYC(2)) dut (
    .sCLK_XVXENVS(clk), .reset_reg_N(rst_n), .dump_start(dump_start), .load_start(load_start),
    .abort(abort), .busy(busy), .done(done), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .data(data_bus), .adr(adr), .write(write), .read(read), .sysex_data_patch_send(send),
    .com_sel(com_sel), .osc_sel(osc_sel), .m1_sel(m1_sel), .m2_sel(m2_sel), .chk_err(chk_err));

  always #5 clk = ~clk;

  // ---------------- responder bus model ----------------
  logic [7:0] mem [4][128];
  logic [7:0] resp = 8'd0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, sel_bad = 0, send_hi = 0, acc_cnt = 0;
  logic load_mode = 1'b0;
  logic [7:0] cap [$];

  assign data_bus = send ? resp : 8'hzz;

  function automatic int sel_bank();
    case ({m2_sel, m1_sel, osc_sel, com_sel})
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  always @(posedge read) begin
    rd_cnt++;
    if (sel_bank() < 0) sel_bad++;
    else resp = mem[sel_bank()][adr];
  end

  always @(negedge write) begin
    if (rst_n) begin
      wr_cnt++;
      if (sel_bank() < 0 || send) sel_bad++;
      else mem[sel_bank()][adr] = data_bus;
    end
  end

  always @(posedge clk) begin
    if (dout_valid && dout_ready) cap.push_back(dout);
    if (din_valid && din_ready) acc_cnt++;
    if (done) done_cnt++;
    if (load_mode && send) send_hi++;
  end

  // ---------------- reference sweep order ----------------
  int pb[$], pa[$];
  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_write"}, write, 1);
    chk({nm, "_read"}, read, 0);
    chk({nm, "_send"}, send, 0);
    chk({nm, "_sels"}, {m2_sel, m1_sel, osc_sel, com_sel}, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_dvalid"}, dout_valid, 0);
    chk({nm, "_dready"}, din_ready, 0);
  endtask

  task automatic run_dump(input bit rnd, input int stall_idx);
    int c0, r0, d0, cyc, sb, rr;
    logic [7:0] hold;
    logic [6:0] sum;
    bit stalled;
    c0 = cap.size(); r0 = rd_cnt; d0 = done_cnt; cyc = 0; stalled = 0; sb = 0;
    @(negedge clk); dump_start = 1; dout_ready = 1;
    @(negedge clk); dump_start = 0;
    while (done_cnt == d0 && cyc < 20000) begin
      if (!stalled && stall_idx >= 0 && dout_valid && (cap.size() - c0) == stall_idx) begin
        stalled = 1; hold = dout; rr = rd_cnt; dout_ready = 0;
        repeat (20) begin
          @(negedge clk);
          if (dout != hold || !dout_valid || rd_cnt != rr) sb++;
        end
        chk("dump_stall_stable", sb, 0);
      end
      dout_ready = rnd ? 1'($urandom % 2) : 1'b1;
      @(negedge clk); cyc++;
    end
    chk("dump_timeout", int'(cyc < 20000), 1);
    repeat (3) @(negedge clk);
    chk("dump_nbytes", cap.size() - c0, NREG + EXTRA);
    sum = 7'd0;
    for (int k = 0; k < NREG && c0 + k < cap.size(); k++) begin
      chk($sformatf("dump_byte%0d", k), cap[c0 + k], mem[pb[k]][pa[k]]);
      sum = sum + mem[pb[k]][pa[k]][6:0];
    end
`ifdef PATCH_CHECKSUM_EN
    if (cap.size() > c0 + NREG) chk("dump_cksum", cap[c0 + NREG], (128 - sum) & 8'h7f);
`endif
    chk("dump_read_pulses", rd_cnt - r0, NREG);
    chk("dump_done_pulses", done_cnt - d0, 1);
    chk("dump_busy_after", busy, 0);
  endtask

  task automatic run_load(input bit rnd, input bit gaps, input int abort_idx, input bit bad_ck);
    logic [7:0] q [$];
    logic [6:0] sum;
    int a0, w0, d0, s0, cyc, idx;
    bit aborted;
    sum = 7'd0;
    for (int k = 0; k < NREG; k++) begin
      q.push_back(rnd ? 8'($urandom) : 8'(k));
      sum = sum + q[k][6:0];
    end
`ifdef PATCH_CHECKSUM_EN
    q.push_back(8'((128 - sum) & 8'h7f) ^ {7'd0, bad_ck});
`endif
    for (int b = 0; b < 4; b++) for (int a = 0; a < 128; a++) mem[b][a] = 8'hee;
    a0 = acc_cnt; w0 = wr_cnt; d0 = done_cnt; s0 = send_hi; cyc = 0; aborted = 0;
    load_mode = 1;
    @(negedge clk); load_start = 1;
    @(negedge clk); load_start = 0;
    while (done_cnt == d0 && cyc < 20000 && !aborted) begin
      idx = acc_cnt - a0;
      if (abort_idx >= 0 && idx == abort_idx + 1 && write == 1'b0) begin
        abort = 1;
        @(posedge clk); #1;
        chk("abort_write_high", write, 1);
        chk("abort_busy", busy, 0);
        chk("abort_din_ready", din_ready, 0);
        chk("abort_sels", {m2_sel, m1_sel, osc_sel, com_sel}, 0);
        abort = 0; aborted = 1;
      end else begin
        if (idx < q.size()) begin
          din = q[idx];
          din_valid = gaps ? 1'($urandom % 2) : 1'b1;
        end else din_valid = 0;
        @(negedge clk); cyc++;
      end
    end
    din_valid = 0;
    repeat (5) @(negedge clk);
    load_mode = 0;
    if (abort_idx >= 0) begin
      chk("abort_happened", aborted, 1);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_write_falls", wr_cnt - w0, abort_idx + 1);
      chk("abort_latched_stands", mem[pb[abort_idx]][pa[abort_idx]], q[abort_idx]);
    end else begin
      chk("load_timeout", int'(cyc < 20000), 1);
      chk("load_write_falls", wr_cnt - w0, NREG);
      for (int k = 0; k < NREG; k++)
        chk($sformatf("load_reg%0d", k), mem[pb[k]][pa[k]], q[k]);
      chk("load_done_pulses", done_cnt - d0, 1);
      chk("load_send_low", send_hi - s0, 0);
`ifdef PATCH_CHECKSUM_EN
      chk("load_chk_err", chk_err, bad_ck);
`endif
    end
    chk("load_busy_after", busy, 0);
  endtask

  typedef struct {
    logic ds, ls;
    logic exp_busy, exp_send, exp_rdy, exp_com;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int offs[10] = '{2, 3, 4, 7, 10, 11, 12, 13, 14, 15};
    int d0;
    for (int a = 1; a <= 15; a++) begin pb.push_back(0); pa.push_back(a); end
    for (int n = 0; n < V_OSC; n++)
      for (int k = 0; k < 10; k++) begin pb.push_back(1); pa.push_back(n * 16 + offs[k]); end
    for (int b = 2; b <= 3; b++)
      for (int a = 0; a < V_OSC * 16; a++) begin pb.push_back(b); pa.push_back(a); end
    for (int b = 0; b < 4; b++) for (int a = 0; a < 128; a++) mem[b][a] = 8'(a ^ b);

    tbl[0] = '{0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 1, 0, 1};
    tbl[2] = '{0, 1, 1, 0, 1, 0};
    tbl[3] = '{1, 1, 1, 1, 0, 1};

    // reset state
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_adr", adr, 0);
    chk("reset_dout", dout, 0);
    chk("reset_chk_err", chk_err, 0);
    rst_n = 1;
    @(negedge clk);

    // start decoding table
    for (int i = 0; i < 4; i++) begin
      dump_start = tbl[i].ds; load_start = tbl[i].ls;
      @(negedge clk);
      dump_start = 0; load_start = 0;
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_send", i), send, tbl[i].exp_send);
      chk($sformatf("tbl%0d_din_ready", i), din_ready, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_com_sel", i), com_sel, tbl[i].exp_com);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk_idle_outputs($sformatf("tbl%0d_abort", i));
    end

    // start while busy is ignored
    load_start = 1; @(negedge clk); load_start = 0;
    dump_start = 1; @(negedge clk); dump_start = 0;
    @(negedge clk);
    chk("busy_start_ignored_send", send, 0);
    chk("busy_start_ignored_rdy", din_ready, 1);
    abort = 1; @(negedge clk); abort = 0;

    run_dump(0, 5);                                   // adr^bank pattern, stall at byte 5
    for (int b = 0; b < 4; b++) for (int a = 0; a < 128; a++) mem[b][a] = 8'($urandom);
    run_dump(1, -1);                                  // random contents, random ready
    run_load(0, 0, -1, 0);                            // bytes 0..182
    run_load(1, 1, -1, 1);                            // random bytes, random valid gaps
    run_load(0, 0, 10, 0);                            // abort while write low on byte 10
    for (int b = 0; b < 4; b++) for (int a = 0; a < 128; a++) mem[b][a] = 8'd0;
    run_dump(0, -1);                                  // all-zero dump

    // asynchronous reset in the middle of a dump
    d0 = done_cnt;
    dout_ready = 1;
    dump_start = 1; @(negedge clk); dump_start = 0;
    repeat (300) @(negedge clk);
    chk("midreset_was_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk_idle_outputs("midreset");
    chk("midreset_adr", adr, 0);
    chk("midreset_dout", dout, 0);
    @(negedge clk); rst_n = 1;
    repeat (5) @(negedge clk);
    chk("midreset_no_done", done_cnt - d0, 0);
    chk("midreset_busy", busy, 0);
    chk("sel_onehot_errors", sel_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
